window_gen3x3: RTL and testbench

- Upstream feeder for the arithmetic core.
- Accepts a row-major pixel stream of cell_bit-wide samples and buffers the two previous image rows in internal line buffers.
- Emits one packed 3x3 window per accepted pixel once a full window exists. Output format is cell_bit*N_cell bits, which matches the core's `in` port.
- Valid-gated stream with no backpressure; the downstream core always accepts.

---
 rtl/window_gen3x3.sv | 130 +++++++++++++
 tb/tb_window_gen3x3.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/window_gen3x3.sv
// 3x3 sliding-window generator: buffers the two previous image rows and emits one
// packed window per accepted pixel once a complete window exists.
module window_gen3x3 #(
    parameter int cell_bit = 8,
    parameter int N_cell   = 9,
    parameter int MAX_W    = 64,
    parameter int W_BITS   = 7
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [cell_bit-1:0]          pixel_in,
    input  logic                         in_valid,
    input  logic                         sof,
    input  logic [W_BITS-1:0]            img_width,
    input  logic [W_BITS-1:0]            img_height,
    output logic [cell_bit*N_cell-1:0]   out,
    output logic                         out_en,
    output logic                         frame_done
);

    localparam int                WIN_W   = cell_bit * N_cell;
    localparam int                LB_AW   = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam logic [W_BITS-1:0] MAX_W_L = W_BITS'(MAX_W);
    localparam logic [W_BITS-1:0] ONE_L   = W_BITS'(1);
    localparam logic [W_BITS-1:0] TWO_L   = W_BITS'(2);
    localparam logic [W_BITS-1:0] THREE_L = W_BITS'(3);

    logic [W_BITS-1:0]   col_q, col_d, row_q, row_d;
    logic [WIN_W-1:0]    win_q, win_d, out_q, out_d;
    logic                out_en_q, out_en_d, frame_done_q, frame_done_d;
    logic [cell_bit-1:0] lb0_q [MAX_W];
    logic [cell_bit-1:0] lb1_q [MAX_W];

    logic [W_BITS-1:0]   x_s, y_s;
    logic [LB_AW-1:0]    lb_addr_s;
    logic [cell_bit-1:0] lb0_rd_s, lb1_rd_s;
    logic                in_range_s, legal_s, last_col_s, last_row_s, lb_we_s;
    logic [WIN_W-1:0]    win_shift_s;

    // Position of the current pixel, line-buffer read and legality of the frame size.
    always_comb begin
        x_s        = sof ? '0 : col_q;
        y_s        = sof ? '0 : row_q;
        in_range_s = (x_s < MAX_W_L);
        lb_addr_s  = x_s[LB_AW-1:0];
        if (in_range_s) begin
            lb0_rd_s = lb0_q[lb_addr_s];
            lb1_rd_s = lb1_q[lb_addr_s];
        end else begin
            lb0_rd_s = '0;
            lb1_rd_s = '0;
        end
        legal_s    = (img_width >= THREE_L) && (img_width <= MAX_W_L) && (img_height >= THREE_L);
        last_col_s = (x_s == (img_width - ONE_L));
        last_row_s = (y_s == (img_height - ONE_L));
        lb_we_s    = in_valid && in_range_s && reset;
    end

    // Window shifts one column left; the new right column is {lb0, lb1, pixel}, top to bottom.
    always_comb begin
        win_shift_s = '0;
        for (int r = 0; r < 3; r++) begin
            win_shift_s[(3*r)*cell_bit   +: cell_bit] = win_q[(3*r+1)*cell_bit +: cell_bit];
            win_shift_s[(3*r+1)*cell_bit +: cell_bit] = win_q[(3*r+2)*cell_bit +: cell_bit];
        end
        win_shift_s[2*cell_bit +: cell_bit] = lb0_rd_s;
        win_shift_s[5*cell_bit +: cell_bit] = lb1_rd_s;
        win_shift_s[8*cell_bit +: cell_bit] = pixel_in;
    end

    // Next-state of counters, window and output registers.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        out_d        = out_q;
        out_en_d     = 1'b0;
        frame_done_d = 1'b0;
        if (in_valid) begin
            win_d    = win_shift_s;
            out_d    = win_shift_s;
            out_en_d = legal_s && (x_s >= TWO_L) && (y_s >= TWO_L);
            if (last_col_s && last_row_s) begin
                col_d        = '0;
                row_d        = '0;
                frame_done_d = 1'b1;
            end else if (last_col_s) begin
                col_d = '0;
                row_d = y_s + ONE_L;
            end else begin
                col_d = x_s + ONE_L;
                row_d = y_s;
            end
        end else begin
            out_en_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            out_q        <= '0;
            out_en_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            out_q        <= out_d;
            out_en_q     <= out_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line buffers: lb0 holds row y-2, lb1 row y-1; contents need no reset.
    always_ff @(posedge clk) begin
        if (lb_we_s) begin
            lb0_q[lb_addr_s] <= lb1_rd_s;
            lb1_q[lb_addr_s] <= pixel_in;
        end
    end

    assign out        = out_q;
    assign out_en     = out_en_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_gen3x3.sv
// Scoreboard bench for window_gen3x3: an image-memory model predicts every window,
// out_en and frame_done; windows are queued on drive and popped on out_en.
module tb_window_gen3x3;

    localparam int CB = 8;
    localparam int NC = 9;
    localparam int MW = 64;
    localparam int WB = 7;

    logic              clk = 1'b0;
    logic              reset;
    logic [CB-1:0]     pixel_in;
    logic              in_valid;
    logic              sof;
    logic [WB-1:0]     img_width;
    logic [WB-1:0]     img_height;
    logic [CB*NC-1:0]  out;
    logic              out_en;
    logic              frame_done;

    window_gen3x3 #(.cell_bit(CB), .N_cell(NC), .MAX_W(MW), .W_BITS(WB)) dut (
        .clk(clk), .reset(reset), .pixel_in(pixel_in), .in_valid(in_valid), .sof(sof),
        .img_width(img_width), .img_height(img_height),
        .out(out), .out_en(out_en), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [CB*NC-1:0] exp_q[$];
    logic [CB-1:0]    img [128][128];
    int               mx = 0, my = 0;
    logic             exp_en = 1'b0, exp_fd = 1'b0, exp_zero = 1'b0;
    int               en_cnt = 0, fd_cnt = 0;
    logic [CB*NC-1:0] last_out = '0;
    logic [CB*NC-1:0] first_out = '0;

    task automatic check(input string tag, input logic [CB*NC-1:0] act, input logic [CB*NC-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [CB*NC-1:0] pack9(input int c0, c1, c2, c3, c4, c5, c6, c7, c8);
        logic [CB*NC-1:0] v;
        v = {CB'(c8), CB'(c7), CB'(c6), CB'(c5), CB'(c4), CB'(c3), CB'(c2), CB'(c1), CB'(c0)};
        return v;
    endfunction

    // One clock: drive inputs, let the edge pass, then advance the reference model.
    task automatic cycle(input logic v, input int p, input logic s, input logic rst_n);
        int x, y;
        logic [CB*NC-1:0] w;
        reset    = rst_n;
        in_valid = v;
        pixel_in = CB'(p);
        sof      = s;
        @(posedge clk);
        exp_en   = 1'b0;
        exp_fd   = 1'b0;
        exp_zero = 1'b0;
        if (!rst_n) begin
            mx = 0; my = 0; exp_zero = 1'b1;
        end else if (v) begin
            x = s ? 0 : mx;
            y = s ? 0 : my;
            img[y][x] = CB'(p);
            if (img_width >= 3 && img_width <= MW && img_height >= 3 && x >= 2 && y >= 2) begin
                exp_en = 1'b1;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        w[(3*r+c)*CB +: CB] = img[y-2+r][x-2+c];
                exp_q.push_back(w);
            end
            if (x == int'(img_width) - 1) begin
                mx = 0;
                if (y == int'(img_height) - 1) begin
                    my = 0; exp_fd = 1'b1;
                end else begin
                    my = y + 1;
                end
            end else begin
                mx = x + 1; my = y;
            end
        end
        #1;
    endtask

    // Monitor: compare control outputs every cycle, pop the scoreboard on out_en.
    always @(negedge clk) begin
        if (reset !== 1'bx) begin
            check("out_en", {71'd0, out_en}, {71'd0, exp_en});
            check("frame_done", {71'd0, frame_done}, {71'd0, exp_fd});
            if (exp_zero) check("out_after_reset", out, '0);
            if (frame_done) fd_cnt++;
            if (out_en) begin
                if (en_cnt == 0) first_out = out;
                en_cnt++;
                last_out = out;
                if (exp_q.size() == 0) begin
                    check("unexpected_window", out, '0);
                    errors += (out == '0) ? 1 : 0;
                end else begin
                    check("window", out, exp_q.pop_front());
                end
            end
        end
    end

    task automatic frame(input int w, input int h, input int base, input int gap, input logic use_sof);
        img_width  = WB'(w);
        img_height = WB'(h);
        for (int i = 0; i < w * h; i++) begin
            cycle(1'b1, base + i, use_sof && (i == 0), 1'b1);
            for (int g = 0; g < gap; g++) cycle(1'b0, 0, 1'b0, 1'b1);
        end
        cycle(1'b0, 0, 1'b0, 1'b1);
    endtask

    task automatic clr_counts();
        en_cnt = 0;
        fd_cnt = 0;
    endtask

    initial begin
        reset = 1'bx; in_valid = 1'b0; pixel_in = '0; sof = 1'b0;
        img_width = WB'(4); img_height = WB'(4);
        @(posedge clk); #1;
        cycle(1'b0, 0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b1);

        // basic 4x4
        clr_counts();
        frame(4, 4, 0, 0, 1'b1);
        check("basic_cnt", 72'(en_cnt), 72'd4);
        check("basic_fd", 72'(fd_cnt), 72'd1);
        check("basic_first", first_out, pack9(0, 1, 2, 4, 5, 6, 8, 9, 10));
        check("basic_last", last_out, pack9(5, 6, 7, 9, 10, 11, 13, 14, 15));

        // same frame with idle gaps
        clr_counts();
        frame(4, 4, 0, 3, 1'b1);
        check("gap_cnt", 72'(en_cnt), 72'd4);
        check("gap_last", last_out, pack9(5, 6, 7, 9, 10, 11, 13, 14, 15));

        // back-to-back 5x3 frames
        clr_counts();
        img_width = WB'(5); img_height = WB'(3);
        for (int i = 0; i < 15; i++) cycle(1'b1, i, i == 0, 1'b1);
        for (int i = 0; i < 15; i++) cycle(1'b1, 100 + i, i == 0, 1'b1);
        cycle(1'b0, 0, 1'b0, 1'b1);
        check("b2b_cnt", 72'(en_cnt), 72'd6);
        check("b2b_fd", 72'(fd_cnt), 72'd2);
        check("b2b_last", last_out, pack9(102, 103, 104, 107, 108, 109, 112, 113, 114));

        // mid-frame abort by sof
        clr_counts();
        img_width = WB'(4); img_height = WB'(4);
        for (int i = 0; i < 6; i++) cycle(1'b1, 50 + i, i == 0, 1'b1);
        frame(4, 4, 200, 0, 1'b1);
        check("abort_cnt", 72'(en_cnt), 72'd4);
        check("abort_fd", 72'(fd_cnt), 72'd1);
        check("abort_first", first_out, pack9(200, 201, 202, 204, 205, 206, 208, 209, 210));

        // reset mid-frame, then a frame without sof
        clr_counts();
        for (int i = 0; i < 10; i++) cycle(1'b1, 30 + i, i == 0, 1'b1);
        cycle(1'b0, 0, 1'b0, 1'b0);
        frame(4, 4, 60, 0, 1'b0);
        check("rst_cnt", 72'(en_cnt), 72'd4);
        check("rst_fd", 72'(fd_cnt), 72'd1);
        check("rst_first", first_out, pack9(60, 61, 62, 64, 65, 66, 68, 69, 70));

        // illegal width
        clr_counts();
        frame(2, 4, 0, 0, 1'b1);
        check("illegal_cnt", 72'(en_cnt), 72'd0);
        check("illegal_fd", 72'(fd_cnt), 72'd1);

        // maximum width
        clr_counts();
        frame(MW, 3, 0, 0, 1'b1);
        check("max_cnt", 72'(en_cnt), 72'(MW - 2));
        check("max_cell8", 72'(last_out[8*CB +: CB]), 72'((MW * 3 - 1) % 256));
        check("sb_empty", 72'(exp_q.size()), 72'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
